// File: rtl/board_pkg.sv
// board_pkg: board geometry, cell index type and click-decoder FSM states.
package board_pkg;
  localparam int BOARD_X0 = 100;
  localparam int BOARD_Y0 = 100;
  localparam int CELL_SIZE = 32;
  localparam int GRID_N = 10;
  typedef logic [3:0] cell_t;
  typedef enum logic [1:0] {S_SAMPLE, S_DIV, S_DONE, S_HAND} state_t;
endpackage

// File: rtl/board_btn_sync.sv
// board_btn_sync: synchronise the left button, detect its rising edge, keep one pending click.
module board_btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic mouse_left,
  input  logic clear,
  output logic click_pend
);
  logic [2:0] sync;
  always_ff @(posedge clk)
    if (!rst) begin
      sync <= '0;
      click_pend <= 1'b0;
    end else begin
      sync <= {sync[1:0], mouse_left};
      // a new edge wins over a same-cycle clear so it survives to the next pass
      click_pend <= (sync[1] & ~sync[2]) | (click_pend & ~clear);
    end
endmodule

// File: rtl/board_click_decoder.sv
// board_click_decoder: map cursor position to board cell for hover and click events.
module board_click_decoder import board_pkg::*; #(
  parameter int BOARD_X0 = board_pkg::BOARD_X0,
  parameter int BOARD_Y0 = board_pkg::BOARD_Y0,
  parameter int CELL_SIZE = board_pkg::CELL_SIZE,
  parameter int GRID_N = board_pkg::GRID_N
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  input  logic        cell_ready,
  output logic        cell_valid,
  output cell_t       cell_col,
  output cell_t       cell_row,
  output logic        hover_valid,
  output cell_t       hover_col,
  output cell_t       hover_row
);
  localparam logic [12:0] CS = 13'(CELL_SIZE);
  localparam logic [12:0] SPAN = 13'(GRID_N * CELL_SIZE);
  state_t state, state_n;
  logic click_pend, click_tag, off, x_go, y_go;
  logic [12:0] dx, dy, rx, ry;
  cell_t col, row;
  assign dx = {1'b0, mouse_xpos} - 13'(BOARD_X0);
  assign dy = {1'b0, mouse_ypos} - 13'(BOARD_Y0);
  assign off = dx[12] | dy[12] | (dx >= SPAN) | (dy >= SPAN);
  assign x_go = rx >= CS;
  assign y_go = ry >= CS;
  board_btn_sync u_btn (
    .clk(clk),
    .rst(rst),
    .mouse_left(mouse_left),
    .clear(state == S_SAMPLE),
    .click_pend(click_pend)
  );
  always_ff @(posedge clk)
    state <= !rst ? S_SAMPLE : state_n;
  always_comb
    state_n = state == S_SAMPLE ? (off ? S_SAMPLE : S_DIV)
            : state == S_DIV    ? (x_go | y_go ? S_DIV : S_DONE)
            : state == S_DONE   ? (click_tag ? S_HAND : S_SAMPLE)
            :                     (cell_ready ? S_SAMPLE : S_HAND);
  always_ff @(posedge clk)
    if (!rst) begin
      rx <= '0;
      ry <= '0;
      col <= '0;
      row <= '0;
      click_tag <= 1'b0;
      cell_valid <= 1'b0;
      cell_col <= '0;
      cell_row <= '0;
      hover_valid <= 1'b0;
      hover_col <= '0;
      hover_row <= '0;
    end else begin
      case (state)
        S_SAMPLE: begin
          rx <= dx;
          ry <= dy;
          col <= '0;
          row <= '0;
          click_tag <= click_pend & ~off;
          if (off) hover_valid <= 1'b0;
        end
        S_DIV: begin
          if (x_go) begin
            rx <= rx - CS;
            col <= col + 4'd1;
          end
          if (y_go) begin
            ry <= ry - CS;
            row <= row + 4'd1;
          end
        end
        S_DONE: begin
          hover_col <= col;
          hover_row <= row;
          hover_valid <= 1'b1;
          if (click_tag) begin
            cell_col <= col;
            cell_row <= row;
            cell_valid <= 1'b1;
          end
        end
        S_HAND: if (cell_ready) cell_valid <= 1'b0;
      endcase
    end
endmodule

// File: tb/tb_board_click_decoder.sv
// tb_board_click_decoder: directed scenarios for hover mapping, click events and handshake.
module tb_board_click_decoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [11:0] mouse_xpos = '0, mouse_ypos = '0;
  logic mouse_left = 1'b0, cell_ready = 1'b0;
  logic cell_valid, hover_valid;
  logic [3:0] cell_col, cell_row, hover_col, hover_row;
  int tests = 0, fails = 0;

  board_click_decoder dut (
    .clk(clk), .rst(rst), .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .mouse_left(mouse_left), .cell_ready(cell_ready), .cell_valid(cell_valid),
    .cell_col(cell_col), .cell_row(cell_row), .hover_valid(hover_valid),
    .hover_col(hover_col), .hover_row(hover_row)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic click(input int n);
    mouse_left = 1'b1;
    cycles(n);
    mouse_left = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (cell_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    cycles(2);
    tests++;
    if ({cell_valid, cell_col, cell_row, hover_valid, hover_col, hover_row} !== 18'd0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b c=%0d r=%0d hv=%b hc=%0d hr=%0d want all 0",
               cell_valid, cell_col, cell_row, hover_valid, hover_col, hover_row);
    end
    rst = 1'b1;
  endtask

  task automatic test_origin;
    int n = 0;
    logic [3:0] c = 4'hf, r = 4'hf;
    mouse_xpos = 100; mouse_ypos = 100; cell_ready = 1'b1;
    cycles(30);
    mouse_left = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i == 20) mouse_left = 1'b0;
      if (cell_valid === 1'b1) begin
        n++; c = cell_col; r = cell_row;
      end
      @(negedge clk);
    end
    tests++;
    if (n !== 1) begin fails++; $display("FAIL origin_pulses: got %0d want 1", n); end
    tests++;
    if (c !== 4'd0 || r !== 4'd0) begin fails++; $display("FAIL origin_cell: got %0d/%0d want 0/0", c, r); end
    tests++;
    if (hover_valid !== 1'b1 || hover_col !== 4'd0 || hover_row !== 4'd0) begin
      fails++;
      $display("FAIL origin_hover: got hv=%b %0d/%0d want 1 0/0", hover_valid, hover_col, hover_row);
    end
  endtask

  task automatic test_corner;
    bit ok;
    int n = 0;
    mouse_xpos = 419; mouse_ypos = 355; cell_ready = 1'b1;
    cycles(30);
    mouse_left = 1'b1;
    wait_valid(28, ok);
    mouse_left = 1'b0;
    tests++;
    if (!ok) begin fails++; $display("FAIL corner_latency: no cell_valid within 28 cycles"); end
    tests++;
    if (cell_col !== 4'd9 || cell_row !== 4'd7) begin
      fails++; $display("FAIL corner_cell: got %0d/%0d want 9/7", cell_col, cell_row);
    end
    cycles(30);
    tests++;
    if (hover_valid !== 1'b1 || hover_col !== 4'd9 || hover_row !== 4'd7) begin
      fails++; $display("FAIL corner_hover: got hv=%b %0d/%0d want 1 9/7", hover_valid, hover_col, hover_row);
    end
    mouse_xpos = 420;
    cycles(30);
    tests++;
    if (hover_valid !== 1'b0) begin fails++; $display("FAIL offedge_hover: got %b want 0", hover_valid); end
    click(3);
    for (int i = 0; i < 60; i++) begin
      if (cell_valid === 1'b1) n++;
      @(negedge clk);
    end
    tests++;
    if (n !== 0) begin fails++; $display("FAIL offedge_click: got %0d valid cycles want 0", n); end
  endtask

  task automatic test_hold;
    bit ok;
    bit bad = 1'b0;
    mouse_xpos = 150; mouse_ypos = 260; cell_ready = 1'b0;
    cycles(30);
    click(3);
    wait_valid(40, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL hold_event: no cell_valid within 40 cycles"); end
    mouse_xpos = 300; mouse_ypos = 300;
    for (int i = 0; i < 50; i++) begin
      if (!bad && (cell_valid !== 1'b1 || cell_col !== 4'd1 || cell_row !== 4'd5 ||
                   hover_valid !== 1'b1 || hover_col !== 4'd1 || hover_row !== 4'd5)) begin
        bad = 1'b1;
        $display("FAIL hold_stable: cycle %0d got v=%b %0d/%0d hover %b %0d/%0d want 1 1/5 hover 1 1/5",
                 i, cell_valid, cell_col, cell_row, hover_valid, hover_col, hover_row);
      end
      @(negedge clk);
    end
    tests++;
    if (bad) fails++;
    cell_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (cell_valid !== 1'b0) begin fails++; $display("FAIL hold_release: got %b want 0", cell_valid); end
    cycles(30);
    tests++;
    if (hover_valid !== 1'b1 || hover_col !== 4'd6 || hover_row !== 4'd6) begin
      fails++; $display("FAIL hold_unfreeze: got hv=%b %0d/%0d want 1 6/6", hover_valid, hover_col, hover_row);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int n = 0;
    logic [3:0] c = 4'hf, r = 4'hf;
    mouse_xpos = 150; mouse_ypos = 260; cell_ready = 1'b0;
    cycles(30);
    click(3);
    wait_valid(40, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL b2b_first: no cell_valid within 40 cycles"); end
    cycles(2);
    click(3);
    cycles(3);
    click(3);
    cycles(6);
    cell_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 80; i++) begin
      if (cell_valid === 1'b1) begin
        n++; c = cell_col; r = cell_row;
      end
      @(negedge clk);
    end
    tests++;
    if (n !== 1) begin fails++; $display("FAIL b2b_extra: got %0d events want 1", n); end
    tests++;
    if (c !== 4'd1 || r !== 4'd5) begin fails++; $display("FAIL b2b_cell: got %0d/%0d want 1/5", c, r); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n = 0;
    mouse_xpos = 419; mouse_ypos = 355; cell_ready = 1'b1;
    cycles(30);
    click(3);
    cycles(4);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({cell_valid, cell_col, cell_row, hover_valid, hover_col, hover_row} !== 18'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got v=%b c=%0d r=%0d hv=%b hc=%0d hr=%0d want all 0",
               cell_valid, cell_col, cell_row, hover_valid, hover_col, hover_row);
    end
    rst = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (cell_valid === 1'b1) n++;
      @(negedge clk);
    end
    tests++;
    if (n !== 0) begin fails++; $display("FAIL midreset_noevent: got %0d valid cycles want 0", n); end
    mouse_left = 1'b1;
    wait_valid(28, ok);
    mouse_left = 1'b0;
    tests++;
    if (!ok || cell_col !== 4'd9 || cell_row !== 4'd7) begin
      fails++; $display("FAIL midreset_recover: got ok=%b %0d/%0d want 1 9/7", ok, cell_col, cell_row);
    end
  endtask

  task automatic test_sweep;
    int bad = 0;
    mouse_xpos = 99; mouse_ypos = 99;
    cycles(30);
    tests++;
    if (hover_valid !== 1'b0) begin fails++; $display("FAIL below_origin: got hv=%b want 0", hover_valid); end
    mouse_ypos = 200;
    for (int x = 100; x <= 419; x++) begin
      mouse_xpos = 12'(x);
      cycles(26);
      if (hover_valid !== 1'b1 || hover_col !== 4'((x - 100) / 32) || hover_row !== 4'd3) begin
        bad++;
        if (bad <= 5)
          $display("FAIL sweep_x%0d: got hv=%b %0d/%0d want 1 %0d/3", x, hover_valid, hover_col, hover_row, (x - 100) / 32);
      end
    end
    tests++;
    if (bad != 0) fails++;
  endtask

  initial begin
    test_reset();
    test_origin();
    test_corner();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/board_click_decoder.md
Name: board_click_decoder

Overview:
- Converts mouse position and left-button state into battleship-board grid coordinates.
- Sits downstream of the mouse-position buffering registers and upstream of the game logic and the draw stages.
- Outputs a continuously refreshed hover cell for highlight drawing.
- Delivers each left click on the board as a one-entry valid/ready cell event; uses an iterative subtract divider, so no hardware divider.

Parameters:
BOARD_X0, 100, x pixel of board top-left corner
BOARD_Y0, 100, y pixel of board top-left corner
CELL_SIZE, 32, cell edge in pixels (>=2)
GRID_N, 10, cells per row/column (GRID_N*CELL_SIZE + origin <= 2047)

Ports:
clk  input  1  pixel clock (40 MHz domain)
rst  input  1  synchronous, active-low reset
mouse_xpos  input  12  cursor x, already registered in clk domain
mouse_ypos  input  12  cursor y, already registered in clk domain
mouse_left  input  1  raw left button, asynchronous to clk
cell_ready  input  1  consumer accepts cell event
cell_valid  output  1  click event pending
cell_col  output  4  clicked column, 0..GRID_N-1
cell_row  output  4  clicked row, 0..GRID_N-1
hover_valid  output  1  cursor currently over board
hover_col  output  4  hovered column
hover_row  output  4  hovered row

Behaviour:
- Reset: one clock, active-low, synchronous; sampled on rising clk when rst==0.
  - All outputs go to 0, click_pend=0, sync flops=0, FSM in S_SAMPLE.
  - Reset mid-operation aborts any division or handshake with no event emitted.
- Button path:
  - 2-flop synchroniser on mouse_left, then a third flop for edge detect.
  - A rising edge sets click_pend; the flag is one deep, so further edges while it is set are dropped.
- FSM S_SAMPLE (1 cycle):
  - Latch dx = xpos - BOARD_X0 and dy = ypos - BOARD_Y0 as 13-bit signed values.
  - Latch click_tag = click_pend, then clear click_pend. An edge arriving in the same cycle is set after the clear, so it is kept for the next pass.
  - col = row = 0.
  - Off-board if dx<0, dy<0, dx>=GRID_N*CELL_SIZE or dy>=GRID_N*CELL_SIZE. When off-board: hover_valid<=0, click_tag discarded, stay in S_SAMPLE.
  - Otherwise -> S_DIV.
- S_DIV:
  - Each cycle, independently per axis: if remainder >= CELL_SIZE, subtract CELL_SIZE and increment the counter.
  - When both remainders are < CELL_SIZE in the same cycle -> S_DONE.
  - Duration is max(col,row)+1 cycles; worst case GRID_N.
- S_DONE (1 cycle):
  - hover_col/row <= col/row; hover_valid <= 1.
  - If click_tag: cell_col/row <= col/row, cell_valid <= 1, -> S_HAND.
  - Else -> S_SAMPLE.
- S_HAND:
  - cell_valid, cell_col and cell_row are held stable until cell_ready==1 in a cycle where cell_valid==1.
  - On that handshake: cell_valid <= 0 next cycle, -> S_SAMPLE.
  - Hover outputs freeze while in S_HAND.
  - If cell_ready is already high at S_DONE, the event lasts exactly 1 cycle.
- Latency:
  - Click edge at the pin to cell_valid: 3 sync/edge cycles + worst remaining pass + 1 + max(col,row)+1 + 1.
  - Bound: <= 2*GRID_N+8 cycles.
- Boundaries:
  - Pixel BOARD_X0 + GRID_N*CELL_SIZE - 1 maps to col GRID_N-1.
  - The next pixel is off-board.
  - Counters never exceed GRID_N-1.

Decomposition:
- Package board_pkg holds:
  - the FSM state enum (S_SAMPLE, S_DIV, S_DONE, S_HAND);
  - shared defaults BOARD_X0, BOARD_Y0, CELL_SIZE, GRID_N, so the board drawer uses identical geometry;
  - the 4-bit cell index typedef.
- One natural sub-module: board_btn_sync (2-flop synchroniser, edge detect, pending flag).

Test Plan:
- Click, hold mouse_left 1 for 20 cycles at (100,100), cell_ready=1 -> one cell_valid pulse with col=0,row=0; hover_valid=1, hover 0/0.
- Cursor at (419,355), click -> cell col=9,row=7; cursor at (420,355) -> hover_valid=0, and a click there yields no cell_valid.
- cell_ready=0 for 50 cycles after a click at (150,260) -> cell_valid=1 with col=1,row=5 stable throughout; hover frozen; clears 1 cycle after cell_ready=1.
- Three clicks during one held handshake -> exactly one extra event after release; third click lost.
- rst=0 for one cycle while in S_DIV with a click pending -> all outputs 0 next cycle; no event after release until a new click.
- Cursor at (99,99) -> hover_valid=0. Cursor swept x=100..419 at y=200 -> hover_col = (x-100)/32, checked each refresh.
